// File: rtl/mult_pkg.sv
// Shared constants for the Booth multiplier controller: state encoding, sizes, Booth decode.
package mult_pkg;

  localparam int unsigned MULT_WIDTH = 32;
  localparam int unsigned MULT_STEPS = 32;

  localparam logic [1:0] StIdle = 2'b00;
  localparam logic [1:0] StRun  = 2'b01;
  localparam logic [1:0] StDone = 2'b10;

  // Booth recoding of {P[1], P[0]}: current multiplier bit and the one shifted out before it
  localparam logic [1:0] BoothNop0 = 2'b00;
  localparam logic [1:0] BoothAdd  = 2'b01;
  localparam logic [1:0] BoothSub  = 2'b10;
  localparam logic [1:0] BoothNop1 = 2'b11;

endpackage

// File: rtl/adder_cla_32_bit.sv
// 32-bit adder built from 4-bit carry-lookahead groups; overflow flags signed overflow.
module adder_cla_32_bit (
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        overflow
);

  logic [31:0] g;
  logic [31:0] p;

  assign g = in1 & in2;
  assign p = in1 ^ in2;

  always_comb begin
    logic [32:0] c;
    logic        gg;
    logic        pg;
    c = '0;
    c[0] = cin;
    for (int blk = 0; blk < 8; blk++) begin
      int b;
      b = blk * 4;
      gg = g[b+3] | (p[b+3] & g[b+2]) | (p[b+3] & p[b+2] & g[b+1]) |
           (p[b+3] & p[b+2] & p[b+1] & g[b]);
      pg = &p[b +: 4];
      for (int i = 0; i < 3; i++) begin
        c[b+i+1] = g[b+i] | (p[b+i] & c[b+i]);
      end
      c[b+4] = gg | (pg & c[b]);
    end
    sum      = p ^ c[31:0];
    overflow = c[32] ^ c[31];
  end

endmodule

// File: rtl/mult_booth_ctrl.sv
// Radix-2 Booth multiplier controller sharing one 32-bit CLA over 32 steps.
// Define MULT_OVF_EN to report products that do not fit in 32 signed bits.
module mult_booth_ctrl
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  logic [1:0]       state_q;
  logic [2*WIDTH:0] p_q;
  logic [2*WIDTH:0] p_d;
  logic [WIDTH-1:0] mcand_q;
  logic [5:0]       step_q;
  logic [WIDTH-1:0] result_q;
  logic             rdy_q;
  logic             last_step;

  logic [WIDTH-1:0] add_in2;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_ovf;

  adder_cla_32_bit u_adder (
    .in1      (p_q[2*WIDTH:WIDTH+1]),
    .in2      (add_in2),
    .cin      (add_cin),
    .sum      (add_sum),
    .overflow (add_ovf)
  );

  // sum[31] ^ overflow is the true sign of the 33-bit add result (matters for mcand = -2^31)
  always_comb begin
    add_in2 = mcand_q;
    add_cin = 1'b0;
    p_d     = {p_q[2*WIDTH], p_q[2*WIDTH:1]};
    unique case (p_q[1:0])
      BoothAdd: begin
        p_d = {add_sum[WIDTH-1] ^ add_ovf, add_sum, p_q[WIDTH:1]};
      end
      BoothSub: begin
        add_in2 = ~mcand_q;
        add_cin = 1'b1;
        p_d     = {add_sum[WIDTH-1] ^ add_ovf, add_sum, p_q[WIDTH:1]};
      end
      BoothNop0, BoothNop1: ;
      default: ;
    endcase
  end

  assign last_step = (step_q == 6'(MULT_STEPS - 1));

`ifdef MULT_OVF_EN
  logic exc_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      exc_q <= 1'b0;
    end else if (state_q == StRun && last_step) begin
      exc_q <= (p_d[2*WIDTH:WIDTH+1] != {WIDTH{p_d[WIDTH]}});
    end
  end

  assign data_exception = exc_q;
`else
  assign data_exception = 1'b0;
`endif

  // Result is captured on the final shift so it is valid together with the ready pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      p_q      <= '0;
      mcand_q  <= '0;
      step_q   <= '0;
      result_q <= '0;
      rdy_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          rdy_q <= 1'b0;
          if (ctrl_MULT) begin
            mcand_q <= data_operandA;
            p_q     <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
            step_q  <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          p_q    <= p_d;
          step_q <= step_q + 6'd1;
          if (last_step) begin
            result_q <= p_d[WIDTH:1];
            rdy_q    <= 1'b1;
            state_q  <= StDone;
          end
        end
        StDone: begin
          rdy_q   <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          rdy_q   <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign data_result    = result_q;
  assign data_resultRDY = rdy_q;

endmodule
